// File: rtl/ltssm_pkg.sv
// Shared LTSSM ordered-set constants and helpers.
// Used by the TS generator and by the TS receive detector.
package ltssm_pkg;

    // Ordered-set symbol values
    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] PADG12 = 8'hF7;
    localparam logic [7:0] D10_2  = 8'h4A;
    localparam logic [7:0] D5_2   = 8'h45;

    // ts_kind encodings
    localparam logic [1:0] TS_KIND_NONE = 2'b00;
    localparam logic [1:0] TS_KIND_TS1  = 2'b01;
    localparam logic [1:0] TS_KIND_TS2  = 2'b10;

    // Symbols 1..5 of a training set, kept together as one reference
    typedef struct packed {
        logic [7:0] link_num;
        logic [7:0] lane_num;
        logic [7:0] n_fts;
        logic [7:0] rate;
        logic [7:0] train_ctrl;
    } ts_fields_t;

    // True when all ten identifier symbols (6..15) equal sym
    function automatic logic pad_all(input logic [79:0] pad, input logic [7:0] sym);
        logic match;
        match = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (pad[i*8 +: 8] != sym) begin
                match = 1'b0;
            end else begin
                match = match;
            end
        end
        return match;
    endfunction

    // Eight-bit increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        logic [7:0] res;
        if (val == 8'hFF) begin
            res = 8'hFF;
        end else begin
            res = val + 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ts_field_decode.sv
// Combinational split of a 16-symbol ordered set into its fields,
// with well-formed TS1/TS2 classification.
module ts_field_decode
    import ltssm_pkg::*;
(
    input  logic [127:0] rx_ts,
    output logic [7:0]   link_num,
    output logic [7:0]   lane_num,
    output logic [7:0]   n_fts,
    output logic [7:0]   rate,
    output logic [7:0]   train_ctrl,
    output logic         well_formed,
    output logic [1:0]   kind
);

    logic [7:0]  sym0_s;
    logic [79:0] pad_s;
    logic        is_ts1_s;
    logic        is_ts2_s;

    // Slice symbols (symbol 0 is the most significant byte) and classify
    always_comb begin
        sym0_s     = rx_ts[127:120];
        link_num   = rx_ts[119:112];
        lane_num   = rx_ts[111:104];
        n_fts      = rx_ts[103:96];
        rate       = rx_ts[95:88];
        train_ctrl = rx_ts[87:80];
        pad_s      = rx_ts[79:0];

        is_ts1_s = (sym0_s == COM) && pad_all(pad_s, D10_2);
        is_ts2_s = (sym0_s == COM) && pad_all(pad_s, D5_2);

        if (is_ts1_s) begin
            kind = TS_KIND_TS1;
        end else if (is_ts2_s) begin
            kind = TS_KIND_TS2;
        end else begin
            kind = TS_KIND_NONE;
        end
        well_formed = is_ts1_s | is_ts2_s;
    end

endmodule

// File: rtl/ts_rx_det.sv
// Training-set receive detector: validates incoming TS1/TS2 ordered sets,
// tracks runs of identical sets and flags when the run is long enough.
module ts_rx_det
    import ltssm_pkg::*;
#(
    parameter int NUM_CONSEC = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         rx_valid,
    input  logic [127:0] rx_ts,
    output logic         ts_rcvd,
    output logic         bad_ts,
    output logic [1:0]   ts_kind,
    output logic [7:0]   link_num,
    output logic [7:0]   lane_num,
    output logic [7:0]   n_fts,
    output logic [7:0]   rate,
    output logic [7:0]   train_ctrl,
    output logic [7:0]   consec_cnt,
    output logic         consec_ok
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [7:0] NUM_CONSEC_L = 8'(NUM_CONSEC);

    // Decoded view of the current beat
    ts_fields_t dec_fields_s;
    logic       dec_wf_s;
    logic [1:0] dec_kind_s;

    // Registered state; the field registers double as the run reference
    // (valid only outside HUNT)
    logic [1:0] state_r,  state_s;
    ts_fields_t fields_r, fields_s;
    logic [1:0] kind_r,   kind_s;
    logic [7:0] cnt_r,    cnt_s;
    logic       ok_r,     ok_s;
    logic       rcvd_r,   rcvd_s;
    logic       bad_r,    bad_s;
    logic       identical_s;

    ts_field_decode u_decode (
        .rx_ts       (rx_ts),
        .link_num    (dec_fields_s.link_num),
        .lane_num    (dec_fields_s.lane_num),
        .n_fts       (dec_fields_s.n_fts),
        .rate        (dec_fields_s.rate),
        .train_ctrl  (dec_fields_s.train_ctrl),
        .well_formed (dec_wf_s),
        .kind        (dec_kind_s)
    );

    // Beat matches the stored reference only when a reference exists
    always_comb begin
        identical_s = 1'b0;
        case (state_r)
            ST_HUNT: begin
                identical_s = 1'b0;
            end
            ST_TRACK, ST_LOCKED: begin
                identical_s = (dec_kind_s == kind_r) && (dec_fields_s == fields_r);
            end
            default: begin
                identical_s = 1'b0;
            end
        endcase
    end

    // Next-state and next-output computation; clear outranks a beat
    always_comb begin
        state_s  = state_r;
        fields_s = fields_r;
        kind_s   = kind_r;
        cnt_s    = cnt_r;
        rcvd_s   = 1'b0;
        bad_s    = 1'b0;

        if (clear) begin
            state_s = ST_HUNT;
            cnt_s   = 8'd0;
            kind_s  = TS_KIND_NONE;
        end else if (rx_valid) begin
            if (!dec_wf_s) begin
                // Malformed: drop the reference, keep last field values visible
                bad_s   = 1'b1;
                cnt_s   = 8'd0;
                kind_s  = TS_KIND_NONE;
                state_s = ST_HUNT;
            end else begin
                rcvd_s   = 1'b1;
                kind_s   = dec_kind_s;
                fields_s = dec_fields_s;
                if (identical_s) begin
                    cnt_s = sat_inc8(cnt_r);
                end else begin
                    cnt_s = 8'd1;
                end
                if (cnt_s >= NUM_CONSEC_L) begin
                    state_s = ST_LOCKED;
                end else begin
                    state_s = ST_TRACK;
                end
            end
        end else begin
            // Idle cycle: everything holds so gaps do not break a run
            state_s = state_r;
        end

        ok_s = (cnt_s >= NUM_CONSEC_L);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_HUNT;
            fields_r <= '0;
            kind_r   <= TS_KIND_NONE;
            cnt_r    <= 8'd0;
            ok_r     <= 1'b0;
            rcvd_r   <= 1'b0;
            bad_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            fields_r <= fields_s;
            kind_r   <= kind_s;
            cnt_r    <= cnt_s;
            ok_r     <= ok_s;
            rcvd_r   <= rcvd_s;
            bad_r    <= bad_s;
        end
    end

    assign ts_rcvd    = rcvd_r;
    assign bad_ts     = bad_r;
    assign ts_kind    = kind_r;
    assign link_num   = fields_r.link_num;
    assign lane_num   = fields_r.lane_num;
    assign n_fts      = fields_r.n_fts;
    assign rate       = fields_r.rate;
    assign train_ctrl = fields_r.train_ctrl;
    assign consec_cnt = cnt_r;
    assign consec_ok  = ok_r;

endmodule

// File: tb/tb_ts_rx_det.sv
// Self-checking bench for ts_rx_det: directed ordered-set sequences, a
// behavioural reference model checked every cycle, plus literal checkpoints.
module tb_ts_rx_det;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         rx_valid;
    logic [127:0] rx_ts;
    logic         ts_rcvd;
    logic         bad_ts;
    logic [1:0]   ts_kind;
    logic [7:0]   link_num;
    logic [7:0]   lane_num;
    logic [7:0]   n_fts;
    logic [7:0]   rate;
    logic [7:0]   train_ctrl;
    logic [7:0]   consec_cnt;
    logic         consec_ok;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    ts_rx_det #(.NUM_CONSEC(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .rx_valid   (rx_valid),
        .rx_ts      (rx_ts),
        .ts_rcvd    (ts_rcvd),
        .bad_ts     (bad_ts),
        .ts_kind    (ts_kind),
        .link_num   (link_num),
        .lane_num   (lane_num),
        .n_fts      (n_fts),
        .rate       (rate),
        .train_ctrl (train_ctrl),
        .consec_cnt (consec_cnt),
        .consec_ok  (consec_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Build an ordered set: kind 1 = TS1 padding, 2 = TS2 padding
    function automatic logic [127:0] mk_ts(input int kind, input logic [7:0] l0,
                                           input logic [7:0] l1, input logic [7:0] nf,
                                           input logic [7:0] rt, input logic [7:0] tc);
        logic [127:0] v;
        logic [7:0]   p;
        p = (kind == 1) ? 8'h4A : 8'h45;
        v = {8'hBC, l0, l1, nf, rt, tc, 80'd0};
        for (int i = 6; i < 16; i++) v[127 - 8*i -: 8] = p;
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    bit         m_have_ref;
    logic [1:0] m_kind;
    logic [7:0] m_f [1:5];
    int         m_run;
    logic       exp_rcvd, exp_bad, exp_ok;
    logic [1:0] exp_kind;
    logic [7:0] exp_f [1:5];
    logic [7:0] exp_cnt;

    always @(posedge clk) begin
        logic [7:0] s [0:15];
        int n4a, n45;
        bit same;
        logic [1:0] k;
        for (int i = 0; i < 16; i++) s[i] = rx_ts[127 - 8*i -: 8];
        exp_rcvd <= 1'b0;
        exp_bad  <= 1'b0;
        if (rst) begin
            m_have_ref = 1'b0; m_kind = 2'b00; m_run = 0;
            for (int i = 1; i <= 5; i++) m_f[i] = 8'h00;
        end else if (clear) begin
            m_have_ref = 1'b0; m_kind = 2'b00; m_run = 0;
        end else if (rx_valid) begin
            n4a = 0; n45 = 0;
            for (int i = 6; i < 16; i++) begin
                if (s[i] == 8'h4A) n4a++;
                if (s[i] == 8'h45) n45++;
            end
            k = (s[0] != 8'hBC) ? 2'b00 : (n4a == 10) ? 2'b01 : (n45 == 10) ? 2'b10 : 2'b00;
            if (k == 2'b00) begin
                exp_bad <= 1'b1;
                m_have_ref = 1'b0; m_kind = 2'b00; m_run = 0;
            end else begin
                exp_rcvd <= 1'b1;
                same = m_have_ref && (k == m_kind);
                for (int i = 1; i <= 5; i++) if (s[i] != m_f[i]) same = 1'b0;
                m_run = same ? ((m_run + 1 > 255) ? 255 : m_run + 1) : 1;
                m_have_ref = 1'b1; m_kind = k;
                for (int i = 1; i <= 5; i++) m_f[i] = s[i];
            end
        end
        exp_kind <= m_kind;
        exp_cnt  <= 8'(m_run);
        exp_ok   <= (m_run >= N);
        for (int i = 1; i <= 5; i++) exp_f[i] <= m_f[i];
    end

    // Single compare process: all outputs against the model, every cycle
    always @(negedge clk) begin
        if (checking) begin
            chk("ts_rcvd",    32'(ts_rcvd),    32'(exp_rcvd));
            chk("bad_ts",     32'(bad_ts),     32'(exp_bad));
            chk("ts_kind",    32'(ts_kind),    32'(exp_kind));
            chk("link_num",   32'(link_num),   32'(exp_f[1]));
            chk("lane_num",   32'(lane_num),   32'(exp_f[2]));
            chk("n_fts",      32'(n_fts),      32'(exp_f[3]));
            chk("rate",       32'(rate),       32'(exp_f[4]));
            chk("train_ctrl", 32'(train_ctrl), 32'(exp_f[5]));
            chk("consec_cnt", 32'(consec_cnt), 32'(exp_cnt));
            chk("consec_ok",  32'(consec_ok),  32'(exp_ok));
        end
    end

    // ---------------- stimulus ----------------
    task automatic beat(input logic [127:0] v);
        rx_valid = 1'b1; rx_ts = v; clear = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0; clear = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1; rx_valid = 1'b0;
        @(negedge clk);
        clear = 1'b0;
    endtask

    logic [127:0] ts1_a, ts1_b, ts2_a, bad_com, bad_mix;
    int pulses;

    initial begin
        ts1_a   = mk_ts(1, 8'hF7, 8'hF7, 8'h00, 8'h02, 8'h00);
        ts1_b   = mk_ts(1, 8'h03, 8'h01, 8'h10, 8'h02, 8'h00);
        ts2_a   = mk_ts(2, 8'h01, 8'h00, 8'h20, 8'h06, 8'h00);
        bad_com = ts1_a; bad_com[127:120] = 8'h00;
        bad_mix = ts1_a; bad_mix[7:0] = 8'h45;

        rst = 1'b1; clear = 1'b0; rx_valid = 1'b0; rx_ts = 128'd0;
        @(negedge clk);
        checking = 1'b1;
        @(negedge clk);
        chk("rst_cnt",  32'(consec_cnt), 32'd0);
        chk("rst_kind", 32'(ts_kind),    32'd0);
        chk("rst_link", 32'(link_num),   32'd0);
        rst = 1'b0;
        idle(1);

        // 8 identical TS1 back to back
        for (int i = 1; i <= 8; i++) begin
            beat(ts1_a);
            chk("run_cnt", 32'(consec_cnt), 32'(i));
            chk("run_ok",  32'(consec_ok),  (i >= 8) ? 32'd1 : 32'd0);
        end
        chk("run_kind", 32'(ts_kind),  32'd1);
        chk("run_link", 32'(link_num), 32'hF7);

        // 7 TS1 then a TS2
        do_clear();
        for (int i = 0; i < 7; i++) beat(ts1_a);
        beat(ts2_a);
        chk("ts2_cnt",  32'(consec_cnt), 32'd1);
        chk("ts2_kind", 32'(ts_kind),    32'd2);
        chk("ts2_ok",   32'(consec_ok),  32'd0);

        // 5 TS1 then a bad COM, then recovery
        do_clear();
        for (int i = 0; i < 5; i++) beat(ts1_a);
        beat(bad_com);
        chk("bad_pulse", 32'(bad_ts),     32'd1);
        chk("bad_cnt",   32'(consec_cnt), 32'd0);
        chk("bad_link",  32'(link_num),   32'hF7);
        beat(ts1_a);
        chk("recov_cnt", 32'(consec_cnt), 32'd1);
        beat(bad_mix);
        chk("mix_bad",   32'(bad_ts),     32'd1);

        // gaps do not break a run
        do_clear();
        for (int i = 0; i < 8; i++) begin
            beat(ts1_a);
            idle(3);
        end
        chk("gap_ok", 32'(consec_ok), 32'd1);

        // different fields restart the run
        beat(ts1_b);
        chk("diff_cnt", 32'(consec_cnt), 32'd1);
        chk("diff_ok",  32'(consec_ok),  32'd0);

        // clear beats a simultaneous beat
        do_clear();
        for (int i = 0; i < 4; i++) beat(ts1_a);
        clear = 1'b1; rx_valid = 1'b1; rx_ts = ts1_a;
        @(negedge clk);
        clear = 1'b0; rx_valid = 1'b0;
        chk("clr_cnt",  32'(consec_cnt), 32'd0);
        chk("clr_kind", 32'(ts_kind),    32'd0);
        chk("clr_rcvd", 32'(ts_rcvd),    32'd0);

        // rst mid-run has priority over clear and a beat
        for (int i = 0; i < 3; i++) beat(ts1_a);
        rst = 1'b1; clear = 1'b1; rx_valid = 1'b1; rx_ts = ts1_a;
        @(negedge clk);
        rst = 1'b0; clear = 1'b0; rx_valid = 1'b0;
        chk("rstrun_cnt",  32'(consec_cnt), 32'd0);
        chk("rstrun_link", 32'(link_num),   32'd0);
        beat(ts1_a);
        chk("rstrun_next", 32'(consec_cnt), 32'd1);

        // 300 identical TS2: saturation
        do_clear();
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            beat(ts2_a);
            if (ts_rcvd) pulses++;
        end
        idle(2);
        chk("sat_pulses", 32'(pulses),     32'd300);
        chk("sat_cnt",    32'(consec_cnt), 32'd255);
        chk("sat_ok",     32'(consec_ok),  32'd1);

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
